tx_frame_path: RTL and testbench

Parametrised TX framing path: maps an incoming dibit stream to I/Q symbols (QPSK or BPSK, selected per frame), prefixes every frame with a fixed header, and repeats each symbol for HOLD output samples. It drives the DAC-side AXI-Stream with 2*IQ_W-bit samples and replaces the fixed-width mod/header/hold chain with one configurable block that also emits frame-boundary flags.

---
 rtl/tx_pkg.sv | 18 +
 rtl/tx_sym_repeat.sv | 79 +++++++
 rtl/tx_frame_path.sv | 134 +++++++++++++
 tb/tb_tx_frame_path.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared encodings and the constellation helper for the TX framing path.
package tx_pkg;

  localparam logic MODE_QPSK = 1'b0;
  localparam logic MODE_BPSK = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_HEADER  = 2'd1;
  localparam state_t ST_PAYLOAD = 2'd2;

  // bit 0 maps to +amp, bit 1 to -amp; caller truncates to its I/Q width
  function automatic int map_bit(input logic b, input int amp);
    return b ? -amp : amp;
  endfunction

endpackage

// File: rtl/tx_sym_repeat.sv
// Output stage: holds one I/Q symbol and repeats it HOLD times on an AXI-Stream
// style handshake, carrying frame start/last tags alongside the sample.
module tx_sym_repeat #(
  parameter int IQ_W = 12,
  parameter int HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [2*IQ_W-1:0] ld_data,
  input  logic              ld_start,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              out_valid,
  output logic [2*IQ_W-1:0] out_data,
  input  logic              out_ready,
  output logic              frame_start,
  output logic              frame_last
);

  localparam int RW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(HOLD - 1);

  logic              valid_q, valid_d;
  logic [2*IQ_W-1:0] data_q, data_d;
  logic              start_q, start_d;
  logic              last_q, last_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic              rep_end;
  logic              accept;

  assign rep_end  = (rep_q == REP_LAST);
  assign accept   = valid_q && out_ready;
  // loading on the final accepted repeat is what removes the inter-symbol bubble
  assign ld_ready = !valid_q || (accept && rep_end);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    start_d = start_q;
    last_d  = last_q;
    rep_d   = rep_q;
    if (ld_valid && ld_ready) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      start_d = ld_start;
      last_d  = ld_last;
      rep_d   = '0;
    end else if (accept) begin
      if (rep_end) begin
        valid_d = 1'b0;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      rep_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      start_q <= start_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign frame_start = valid_q && start_q && (rep_q == '0);
  assign frame_last  = valid_q && last_q && rep_end;

endmodule

// File: rtl/tx_frame_path.sv
// TX framing path: header + mapped payload symbols, each repeated HOLD times.
//   state      | meaning
//   ST_IDLE    | waiting for in_valid; latches mode and loads header symbol 0
//   ST_HEADER  | loading header symbols 1..HDR_LEN-1 (always QPSK)
//   ST_PAYLOAD | consuming PAYLOAD_LEN dibits; leaves when frame_last is accepted
module tx_frame_path
  import tx_pkg::*;
#(
  parameter int                  IQ_W        = 12,
  parameter int                  AMP         = 2**(IQ_W-1) - 1,
  parameter int                  HDR_LEN     = 16,
  parameter logic [2*HDR_LEN-1:0] HDR_PATTERN = 32'hF0F0_3C5A,
  parameter int                  PAYLOAD_LEN = 64,
  parameter int                  HOLD        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [1:0]        in_bits,
  output logic              in_ready,
  output logic              out_valid,
  output logic [2*IQ_W-1:0] out_data,
  input  logic              out_ready,
  output logic              frame_start,
  output logic              frame_last
);

  localparam int HC_W = $clog2(HDR_LEN + 1);
  localparam int PC_W = $clog2(PAYLOAD_LEN + 1);

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [PC_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic              mode_q, mode_d;

  logic [1:0]        hdr_bits;
  logic [IQ_W-1:0]   sym_i, sym_q;
  logic              ld_valid, ld_ready, ld_start, ld_last;
  logic              pay_open;

  assign pay_open = (pay_cnt_q < PC_W'(PAYLOAD_LEN));

  always_comb begin
    hdr_bits = '0;
    for (int k = 0; k < HDR_LEN; k++) begin
      if (hdr_cnt_q == HC_W'(k)) hdr_bits = HDR_PATTERN[2*k +: 2];
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    mode_d    = mode_q;
    ld_valid  = 1'b0;
    ld_start  = 1'b0;
    ld_last   = 1'b0;
    in_ready  = 1'b0;
    // header pairs put the lower bit on I, the upper bit on Q
    sym_i     = IQ_W'(map_bit(hdr_bits[0], AMP));
    sym_q     = IQ_W'(map_bit(hdr_bits[1], AMP));
    case (state_q)
      ST_IDLE: begin
        if (in_valid && ld_ready) begin
          mode_d    = mode;
          ld_valid  = 1'b1;
          ld_start  = 1'b1;
          hdr_cnt_d = HC_W'(1);
          state_d   = (HDR_LEN == 1) ? ST_PAYLOAD : ST_HEADER;
        end
      end
      ST_HEADER: begin
        ld_valid = 1'b1;
        if (ld_ready) begin
          hdr_cnt_d = hdr_cnt_q + 1'b1;
          if (hdr_cnt_q == HC_W'(HDR_LEN - 1)) state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (mode_q == MODE_BPSK) begin
          sym_i = IQ_W'(map_bit(in_bits[0], AMP));
          sym_q = '0;
        end else begin
          sym_i = IQ_W'(map_bit(in_bits[1], AMP));
          sym_q = IQ_W'(map_bit(in_bits[0], AMP));
        end
        in_ready = pay_open && ld_ready;
        ld_valid = pay_open && in_valid;
        ld_last  = (pay_cnt_q == PC_W'(PAYLOAD_LEN - 1));
        if (in_valid && in_ready) pay_cnt_d = pay_cnt_q + 1'b1;
        if (out_valid && out_ready && frame_last) begin
          state_d   = ST_IDLE;
          hdr_cnt_d = '0;
          pay_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      mode_q    <= MODE_QPSK;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      mode_q    <= mode_d;
    end
  end

  tx_sym_repeat #(
    .IQ_W (IQ_W),
    .HOLD (HOLD)
  ) u_stage (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_data     ({sym_i, sym_q}),
    .ld_start    (ld_start),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .frame_start (frame_start),
    .frame_last  (frame_last)
  );

endmodule

// File: tb/tb_tx_frame_path.sv
// Randomised bench for tx_frame_path against a queue-based frame model.
module tb_tx_frame_path;

  localparam int IQ_W = 12;
  localparam int AMP  = 2047;
  localparam int HL   = 2;
  localparam logic [3:0] HPAT = 4'b0110;
  localparam int PL   = 3;
  localparam int HOLD = 4;
  localparam int FLEN = (HL + PL) * HOLD;

  logic clk, rst, mode, in_valid, in_ready, out_valid, out_ready, frame_start, frame_last;
  logic [1:0] in_bits;
  logic [2*IQ_W-1:0] out_data;

  int total = 0;
  int bad = 0;

  logic [1:0] tx_bits[$];
  logic       tx_mode[$];
  logic [2*IQ_W-1:0] got_d[$], exp_d[$];
  logic got_s[$], got_l[$], exp_s[$], exp_l[$];
  int rdy_mode = 0;
  int und_after = -1;
  int und_len = 0;
  int stall_err, stalls, bubbles, b2b_gap, lat;

  tx_frame_path #(
    .IQ_W(IQ_W), .AMP(AMP), .HDR_LEN(HL), .HDR_PATTERN(HPAT),
    .PAYLOAD_LEN(PL), .HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_bits(in_bits),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .frame_start(frame_start), .frame_last(frame_last)
  );

  always #5 clk = ~clk;

  function automatic logic [IQ_W-1:0] amp_of(input logic b);
    return b ? IQ_W'(-AMP) : IQ_W'(AMP);
  endfunction

  // Expected sample stream: header symbols then payload symbols, each HOLD times.
  task automatic build_expected();
    exp_d.delete(); exp_s.delete(); exp_l.delete();
    for (int f = 0; f < tx_mode.size(); f++) begin
      for (int s = 0; s < HL + PL; s++) begin
        logic [3:0] hb;
        logic [1:0] b;
        logic [2*IQ_W-1:0] v;
        if (s < HL) begin
          hb = HPAT >> (2 * s);
          v = {amp_of(hb[0]), amp_of(hb[1])};
        end else begin
          b = tx_bits[f * PL + s - HL];
          v = tx_mode[f] ? {amp_of(b[0]), {IQ_W{1'b0}}} : {amp_of(b[1]), amp_of(b[0])};
        end
        for (int h = 0; h < HOLD; h++) begin
          exp_d.push_back(v);
          exp_s.push_back(s == 0 && h == 0);
          exp_l.push_back(s == HL + PL - 1 && h == HOLD - 1);
        end
      end
    end
  endtask

  task automatic load_random(input int nf);
    tx_bits.delete(); tx_mode.delete();
    for (int f = 0; f < nf; f++) begin
      tx_mode.push_back(1'($urandom));
      for (int k = 0; k < PL; k++) tx_bits.push_back(2'($urandom));
    end
  endtask

  task automatic run_stream(input int n_exp, input int max_cyc);
    int idx = 0;
    int pause = 0;
    int cyc = 0;
    int gap_cnt = 0;
    int first_iv = -1;
    int first_ov = -1;
    logic in_frame = 1'b0;
    logic gap_on = 1'b0;
    logic held = 1'b0;
    logic [2*IQ_W-1:0] hd = '0;
    logic hs = 1'b0;
    logic hl = 1'b0;
    got_d.delete(); got_s.delete(); got_l.delete();
    stall_err = 0; stalls = 0; bubbles = 0; b2b_gap = -1;
    while (got_d.size() < n_exp && cyc < max_cyc) begin
      @(negedge clk);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = (idx < tx_bits.size()) && (pause == 0);
      if (in_valid) in_bits = tx_bits[idx];
      else in_bits = 2'($urandom);
      if (idx < tx_bits.size() && idx % PL == 0) mode = tx_mode[idx / PL];
      else mode = 1'($urandom);
      #1;
      if (in_valid && first_iv < 0) first_iv = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (held && (!out_valid || out_data !== hd || frame_start !== hs || frame_last !== hl))
        stall_err++;
      held = out_valid && !out_ready;
      hd = out_data; hs = frame_start; hl = frame_last;
      if (held) stalls++;
      if (!out_valid) begin
        if (in_frame) bubbles++;
        if (gap_on) gap_cnt++;
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_s.push_back(frame_start);
        got_l.push_back(frame_last);
        if (frame_start) begin
          in_frame = 1'b1;
          if (gap_on) begin b2b_gap = gap_cnt; gap_on = 1'b0; end
        end
        if (frame_last) begin in_frame = 1'b0; gap_on = 1'b1; gap_cnt = 0; end
      end
      if (in_valid && in_ready) begin
        idx++;
        if (idx == und_after) pause = und_len;
      end else if (pause > 0) begin
        pause--;
      end
      cyc++;
    end
    lat = first_ov - first_iv;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
    total++; if (frame_last !== 1'b0) begin bad++; $display("FAIL reset_frame_last got=%b want=0", frame_last); end
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%b want=0", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_qpsk_continuous();
    tx_bits = '{2'b00, 2'b11, 2'b10};
    tx_mode = '{1'b0};
    rdy_mode = 0; und_after = -1;
    build_expected();
    run_stream(FLEN, 200);
    total++; if (got_d.size() != FLEN) begin bad++; $display("FAIL qpsk_count got=%0d want=%0d", got_d.size(), FLEN); end
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k] || got_l[k] !== exp_l[k]) begin
        bad++;
        $display("FAIL qpsk_sample[%0d] got=%h/%b/%b want=%h/%b/%b", k, got_d[k], got_s[k], got_l[k], exp_d[k], exp_s[k], exp_l[k]);
      end
    end
    if (got_d.size() == FLEN) begin
      total++; if (got_d[0] !== 24'h7FF801) begin bad++; $display("FAIL qpsk_hdr0 got=%h want=7ff801", got_d[0]); end
      total++; if (got_d[FLEN-1] !== 24'h8017FF) begin bad++; $display("FAIL qpsk_last got=%h want=8017ff", got_d[FLEN-1]); end
    end
    total++; if (lat != 1) begin bad++; $display("FAIL qpsk_latency got=%0d want=1", lat); end
    total++; if (bubbles != 0) begin bad++; $display("FAIL qpsk_bubbles got=%0d want=0", bubbles); end
  endtask

  task automatic test_bpsk();
    tx_bits = '{2'b01, 2'($urandom), 2'($urandom)};
    tx_mode = '{1'b1};
    rdy_mode = 0; und_after = -1;
    build_expected();
    run_stream(FLEN, 200);
    total++; if (got_d.size() != FLEN) begin bad++; $display("FAIL bpsk_count got=%0d want=%0d", got_d.size(), FLEN); end
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k] || got_l[k] !== exp_l[k]) begin
        bad++;
        $display("FAIL bpsk_sample[%0d] got=%h/%b/%b want=%h/%b/%b", k, got_d[k], got_s[k], got_l[k], exp_d[k], exp_s[k], exp_l[k]);
      end
    end
    if (got_d.size() == FLEN) begin
      total++; if (got_d[HL*HOLD] !== 24'h801000) begin bad++; $display("FAIL bpsk_pay0 got=%h want=801000", got_d[HL*HOLD]); end
      total++; if (got_d[0] !== 24'h7FF801) begin bad++; $display("FAIL bpsk_hdr0 got=%h want=7ff801", got_d[0]); end
    end
  endtask

  task automatic test_backpressure();
    load_random(1);
    rdy_mode = 1; und_after = -1;
    build_expected();
    run_stream(FLEN, 400);
    total++; if (got_d.size() != FLEN) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_d.size(), FLEN); end
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k] || got_l[k] !== exp_l[k]) begin
        bad++;
        $display("FAIL bp_sample[%0d] got=%h/%b/%b want=%h/%b/%b", k, got_d[k], got_s[k], got_l[k], exp_d[k], exp_s[k], exp_l[k]);
      end
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stable got=%0d unstable stalls want=0", stall_err); end
    total++; if (stalls == 0) begin bad++; $display("FAIL bp_stalls_seen got=0 want>0"); end
  endtask

  task automatic test_underrun();
    load_random(1);
    rdy_mode = 0; und_after = 1; und_len = 5;
    build_expected();
    run_stream(FLEN, 400);
    und_after = -1;
    total++; if (got_d.size() != FLEN) begin bad++; $display("FAIL und_count got=%0d want=%0d", got_d.size(), FLEN); end
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k] || got_l[k] !== exp_l[k]) begin
        bad++;
        $display("FAIL und_sample[%0d] got=%h/%b/%b want=%h/%b/%b", k, got_d[k], got_s[k], got_l[k], exp_d[k], exp_s[k], exp_l[k]);
      end
    end
    // sym0 covers the first HOLD cycles of the pause, then the stage empties
    total++; if (bubbles != und_len - HOLD + 1) begin bad++; $display("FAIL und_gap got=%0d want=%0d", bubbles, und_len - HOLD + 1); end
  endtask

  task automatic test_reset_mid_frame();
    load_random(1);
    rdy_mode = 0; und_after = -1;
    run_stream(HL * HOLD + 2, 200);
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL midrst_out got=%b/%h want=0/0", out_valid, out_data); end
    total++; if (in_ready !== 1'b0 || frame_start !== 1'b0 || frame_last !== 1'b0) begin
      bad++; $display("FAIL midrst_flags got=%b%b%b want=000", in_ready, frame_start, frame_last);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    load_random(1);
    build_expected();
    run_stream(FLEN, 200);
    total++; if (got_d.size() != FLEN) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", got_d.size(), FLEN); end
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k] || got_l[k] !== exp_l[k]) begin
        bad++;
        $display("FAIL midrst_sample[%0d] got=%h/%b/%b want=%h/%b/%b", k, got_d[k], got_s[k], got_l[k], exp_d[k], exp_s[k], exp_l[k]);
      end
    end
    total++; if (lat != 1) begin bad++; $display("FAIL midrst_latency got=%0d want=1", lat); end
  endtask

  task automatic test_back_to_back();
    load_random(2);
    rdy_mode = 0; und_after = -1;
    build_expected();
    run_stream(2 * FLEN, 400);
    total++; if (got_d.size() != 2 * FLEN) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got_d.size(), 2 * FLEN); end
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k] || got_l[k] !== exp_l[k]) begin
        bad++;
        $display("FAIL b2b_sample[%0d] got=%h/%b/%b want=%h/%b/%b", k, got_d[k], got_s[k], got_l[k], exp_d[k], exp_s[k], exp_l[k]);
      end
    end
    total++; if (b2b_gap != 1) begin bad++; $display("FAIL b2b_gap got=%0d want=1", b2b_gap); end
  endtask

  task automatic test_random_frames();
    load_random(3);
    rdy_mode = 2; und_after = 2; und_len = 3;
    build_expected();
    run_stream(3 * FLEN, 1500);
    und_after = -1;
    total++; if (got_d.size() != 3 * FLEN) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", got_d.size(), 3 * FLEN); end
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k] || got_l[k] !== exp_l[k]) begin
        bad++;
        $display("FAIL rnd_sample[%0d] got=%h/%b/%b want=%h/%b/%b", k, got_d[k], got_s[k], got_l[k], exp_d[k], exp_s[k], exp_l[k]);
      end
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL rnd_stable got=%0d unstable stalls want=0", stall_err); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_bits = 2'b00; out_ready = 1'b0;
    test_reset();
    test_qpsk_continuous();
    test_bpsk();
    test_backpressure();
    test_underrun();
    test_reset_mid_frame();
    test_back_to_back();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
